// File: rtl/sram_master.sv
// Turns a one-cycle request/acknowledge handshake into a timed cycle on the asynchronous 8-bit SRAM bus.
// Setup, strobe and hold widths are set in clock cycles. The address, the chip select and both strobes are registered.
module sram_master #(
    parameter int unsigned SETUP  = 1,
    parameter int unsigned STROBE = 2,
    parameter int unsigned HOLD   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [18:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata,
    output logic        o_ack,
    output logic        o_busy,
    output logic [18:0] o_sram_a,
    inout  wire  [7:0]  io_sram_d,
    output logic        o_sram_cs,
    output logic        o_sram_oe,
    output logic        o_sram_we
);

    if (SETUP < 1 || SETUP > 15) begin : g_bad_setup
        $error("sram_master: SETUP=%0d outside 1..15", SETUP);
    end
    if (STROBE < 1 || STROBE > 15) begin : g_bad_strobe
        $error("sram_master: STROBE=%0d outside 1..15", STROBE);
    end
    if (HOLD > 15) begin : g_bad_hold
        $error("sram_master: HOLD=%0d outside 0..15", HOLD);
    end

    localparam logic [3:0] LD_SETUP  = 4'(SETUP - 1);
    localparam logic [3:0] LD_STROBE = 4'(STROBE - 1);
    localparam logic [3:0] LD_HOLD   = 4'((HOLD == 0) ? 0 : HOLD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_wr;
    logic [18:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_ack;
    logic        r_cs, r_oe, r_we;
    logic        r_d_oe;
    logic        w_accept;
    logic        w_capture;
    logic        w_wr;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_accept   = 1'b1;
                    w_next     = ST_SETUP;
                    w_cnt_next = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_next     = ST_STROBE;
                    w_cnt_next = LD_STROBE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_capture = ~r_wr;
                    if (HOLD > 0) begin
                        w_next     = ST_HOLD;
                        w_cnt_next = LD_HOLD;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobe and data-enable registers are set from the next state, so the pins line up with the state.
    assign w_wr = w_accept ? i_wr : r_wr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_addr  <= 19'd0;
            r_wdata <= 8'd0;
            r_rdata <= 8'd0;
            r_ack   <= 1'b0;
            r_cs    <= 1'b1;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_d_oe  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
            if (w_accept) begin
                r_wr    <= i_wr;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            if (w_capture) begin
                r_rdata <= io_sram_d;
            end
            r_cs   <= (w_next == ST_IDLE);
            r_oe   <= !((w_next == ST_STROBE) && !w_wr);
            r_we   <= !((w_next == ST_STROBE) && w_wr);
            r_d_oe <= (w_next != ST_IDLE) && w_wr;
        end
    end

    assign io_sram_d = r_d_oe ? r_wdata : 8'hzz;
    assign o_rdata   = r_rdata;
    assign o_ack     = r_ack;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_sram_a  = r_addr;
    assign o_sram_cs = r_cs;
    assign o_sram_oe = r_oe;
    assign o_sram_we = r_we;

endmodule

// File: doc/sram_master.md
# sram_master

FPGA-side initiator for the board's asynchronous 8-bit SRAM bus. It converts a single-cycle request/acknowledge handshake from internal FPGA logic into a properly timed SRAM read or write cycle on SRAM_A/SRAM_D/SRAM_CS/SRAM_OE/SRAM_WE. The ARM external bus uses the same active-low strobe protocol. Setup, strobe and hold widths are parameterised in clock cycles, so one design meets SRAM timing at any FPGA clock rate.

## Interface
- SETUP, 1: cycles with CS low and address/data valid before the strobe; range 1..15.
- STROBE, 2: cycles OE or WE is held low; range 1..15.
- HOLD, 1: cycles CS low, address/data held after the strobe rises; range 0..15.

- CLK  input  1  single clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  1  transaction request; sampled only in IDLE.
- WR  input  1  1 = write, 0 = read; latched with REQ.
- ADDR  input  19  byte address; latched with REQ.
- WDATA  input  8  write data; latched with REQ.
- RDATA  output  8  read data; valid from the ACK cycle until the next read completes.
- ACK  output  1  one-cycle completion pulse.
- BUSY  output  1  high from acceptance through the last HOLD cycle.
- SRAM_A  output  19  SRAM address, registered.
- SRAM_D  inout  8  SRAM data; driven only during write transactions, else high-Z.
- SRAM_CS  output  1  chip select, active low, registered.
- SRAM_OE  output  1  output enable, active low, registered.
- SRAM_WE  output  1  write enable, active low, registered.

## Operation
- States: IDLE, SETUP, STROBE, HOLD; 4-bit down-counter for phase length.
- IDLE: REQ=1 latches WR, ADDR and WDATA, loads the counter with SETUP-1, and moves to SETUP. Otherwise it stays in IDLE.
- SETUP: CS=0, OE=1, WE=1, SRAM_A=latched address. For writes, SRAM_D is driven with latched data.
  - When the counter reaches 0, load STROBE-1 and go to STROBE.
- STROBE: CS=0. OE=0 for reads, WE=0 for writes; the other strobe stays at 1.
  - When the counter reaches 0:
    - For reads, capture SRAM_D into RDATA on that edge.
    - If HOLD>0, load HOLD-1 and go to HOLD; otherwise go to IDLE.
- HOLD: CS=0, OE=1, WE=1; address and write data still held. When the counter reaches 0, go to IDLE.
- ACK is high for exactly the first IDLE cycle after a transaction. BUSY=0 in that cycle.
- REQ seen in that ACK cycle is accepted, giving back-to-back transactions.
- REQ while BUSY=1 is ignored; there is no queueing. The requester holds REQ until it sees ACK, or re-asserts it.
- SRAM_D output enable: asserted for a write in SETUP, STROBE and HOLD; released on entry to IDLE.
- The read path never drives SRAM_D.
- Address and strobes change only on clock edges. Each IDLE cycle returns CS to 1, so there is at least 1 CS-high cycle between transactions.
- RST (any state, including mid-strobe), effective at the next edge:
  - state=IDLE; CS, OE and WE go to 1; SRAM_D is released.
  - No ACK for the aborted transaction.

## Timing
- Reset values: SRAM_CS=1, SRAM_OE=1, SRAM_WE=1, SRAM_A=0, SRAM_D=Z, RDATA=0, ACK=0, BUSY=0.
- Timing is counted from the edge that samples REQ=1 (edge 0):
  - SETUP occupies cycles 1..SETUP.
  - STROBE occupies the next STROBE cycles.
  - HOLD occupies the next HOLD cycles.
  - ACK falls in cycle SETUP+STROBE+HOLD+1.
- Defaults: ACK in cycle 5. Minimum transaction period = SETUP+STROBE+HOLD+1 cycles.
- Read data is sampled at the end of the last strobe cycle. The SRAM access time must be below (SETUP+STROBE) clock periods minus pad delays; this is the integrator's responsibility.
- Writes: data is stable SETUP cycles before WE falls and HOLD cycles after WE rises. The SRAM latches on the WE rising edge.
- Out-of-range parameters are caught with a simulation-time error.

## Test plan
- Reset: assert RST for 2 cycles with random inputs.
  - Required: CS/OE/WE=1, SRAM_A=0, SRAM_D=Z, ACK=0, BUSY=0.
- Write, defaults: REQ=1, WR=1, ADDR=0x5A5A5, WDATA=0xC3 for one cycle.
  - Required: CS low cycles 1-4; WE low cycles 2-3; SRAM_D=0xC3 cycles 1-4; SRAM_D=Z in cycle 5; ACK pulse in cycle 5.
- Read, defaults: SRAM model returns 0x7E at 0x00010.
  - Required: OE low cycles 2-3, SRAM_D never driven, RDATA=0x7E in cycle 5 with ACK.
- Back-to-back: REQ held high across a write then a read.
  - Required: the second SETUP starts in the cycle after ACK, with exactly 1 CS-high cycle between transactions.
  - A REQ pulse in cycle 3 of a transaction is ignored.
- Parameter set SETUP=3, STROBE=4, HOLD=0 (read).
  - Required: OE low cycles 4-7, ACK in cycle 8, CS rises in cycle 8.
- Reset mid-strobe: RST in cycle 2 of a write.
  - Required: next cycle CS=WE=1, SRAM_D=Z, no ACK.
  - A subsequent read runs normally.
